uart_cmd_slave: RTL and testbench
=================================

Name: uart_cmd_slave

Overview:
Receive-side counterpart of the UART command master. Sits between a UART byte transceiver and the command-processing logic. Assembles 3 received bytes, high byte first, into a 24-bit command and presents it with a ready/clear handshake. Also transmits a 1-byte response back over the transceiver, and resynchronises framing with an inter-byte timeout.

Parameters:
TO_CYCLES, 1000000, max clk cycles allowed between bytes of one frame before the partial frame is discarded (>=4)

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
rx_rdy  in  1  transceiver has a received byte pending
rx_data  in  8  received byte, valid while rx_rdy=1
clr_rx_rdy  out  1  consume pending byte (combinational)
cmd  out  24  last complete command; byte0 in [23:16], byte1 in [15:8], byte2 in [7:0]
cmd_rdy  out  1  cmd valid, held until cleared
clr_cmd_rdy  in  1  consumer acknowledges cmd
resp  in  8  response byte to send
send_resp  in  1  request to transmit resp (1-cycle pulse)
trmt  out  1  start transmit pulse to transceiver
tx_data  out  8  byte being transmitted
tx_done  in  1  transceiver finished the byte
resp_sent  out  1  1-cycle pulse when the response is done
frame_err  out  1  1-cycle pulse on inter-byte timeout

Behaviour:
- Clock and reset: clk, rising edge. Reset is rst_n, asynchronous, active-low.
- Reset values: cmd=0, cmd_rdy=0, trmt=0, tx_data=0, resp_sent=0, frame_err=0. Internal assembly register=0, timeout counter=0, RX FSM=WAIT_B0, TX FSM=TX_IDLE.
- Reset mid-frame or mid-transmit: all state is abandoned immediately.
- RX FSM states: WAIT_B0, WAIT_B1, WAIT_B2, CMD_VALID.
- clr_rx_rdy = rx_rdy && state in {WAIT_B0, WAIT_B1, WAIT_B2}. Each byte is captured on the edge where clr_rx_rdy=1.
- WAIT_B0 with rx_rdy: rx_data goes to assembly[23:16]; next state WAIT_B1.
- WAIT_B1 with rx_rdy: rx_data goes to assembly[15:8]; next state WAIT_B2.
- WAIT_B2 with rx_rdy: cmd <= {assembly[23:8], rx_data}; cmd_rdy <= 1; next state CMD_VALID.
  - Latency: cmd and cmd_rdy are visible the cycle after the third byte's capture edge.
- cmd updates atomically, only on a complete frame. Partial frames never appear on cmd.
- CMD_VALID: rx_rdy is not consumed (clr_rx_rdy=0); the byte stays pending in the transceiver. On clr_cmd_rdy: cmd_rdy <= 0, next state WAIT_B0. cmd keeps its value.
- clr_cmd_rdy while not in CMD_VALID: ignored.
- clr_cmd_rdy and rx_rdy in the same CMD_VALID cycle: the byte is not consumed that cycle. It is captured as byte0 the next cycle.
- Timeout counter:
  - Cleared on every byte capture and whenever the state is WAIT_B0 or CMD_VALID.
  - Increments each cycle in WAIT_B1/WAIT_B2 without rx_rdy.
  - When the counter == TO_CYCLES-1 in WAIT_B1/WAIT_B2 without rx_rdy: next state WAIT_B0, frame_err pulses 1 cycle, assembly discarded, cmd and cmd_rdy untouched.
  - rx_rdy in the same cycle as expiry: the byte wins and no error is raised.
- TX FSM states: TX_IDLE, TX_BUSY.
- TX_IDLE with send_resp: tx_data <= resp; trmt pulses 1 cycle, registered, high the cycle after send_resp; next state TX_BUSY.
- TX_BUSY with tx_done: resp_sent pulses 1 cycle, next state TX_IDLE.
- send_resp during TX_BUSY: ignored, no queuing. tx_done in TX_IDLE: ignored.
- RX and TX paths are fully independent and may be active simultaneously.
- send_resp on the same edge as tx_done in TX_BUSY: ignored (FSM still BUSY). The requester waits for resp_sent.

Test Plan:
- Reset then bytes 0xA5, 0x3C, 0x0F, each arriving 50 cycles apart -> 3 clr_rx_rdy pulses; cmd=0xA53C0F and cmd_rdy=1 one cycle after the third capture; cmd_rdy stays high 100 cycles until clr_cmd_rdy, then drops next cycle.
- With cmd_rdy=1, deliver byte 0x11 -> clr_rx_rdy stays 0 and cmd unchanged. Pulse clr_cmd_rdy -> 0x11 is captured as byte0 the following cycle. Then 0x22, 0x33 -> cmd=0x112233.
- TO_CYCLES=16: send 0xDE, 0xAD, then idle 16 cycles -> frame_err pulses exactly once and cmd_rdy stays 0. Then send 0x01, 0x02, 0x03 -> cmd=0x010203 (no 0xDEAD remnants).
- TO_CYCLES=16: deliver the second byte exactly at the expiry cycle -> no frame_err, frame continues.
- send_resp with resp=0xA5 -> trmt 1-cycle pulse with tx_data=0xA5. send_resp with resp=0x5A while busy -> no second trmt, tx_data stays 0xA5. tx_done -> one resp_sent pulse.
- Assert rst_n low after byte1 of a frame and while TX_BUSY -> all outputs 0. After release, a full frame 0x123456 decodes correctly and a new send_resp transmits normally.

Source files
------------

// File: rtl/uart_cmd_slave.sv
`default_nettype none
// ============================================================================
// uart_cmd_slave : assembles 3-byte commands from a UART receiver and sends
//                  1-byte responses back through the same transceiver.
// Revision       : 1.0
// ============================================================================
module uart_cmd_slave #(
    parameter int TO_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        frame_err
);

    localparam int                 C_CNT_W   = $clog2(TO_CYCLES);
    localparam logic [C_CNT_W-1:0] C_TO_LAST = C_CNT_W'(TO_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_B0   = 2'd0,
        WAIT_B1   = 2'd1,
        WAIT_B2   = 2'd2,
        CMD_VALID = 2'd3
    } rx_state_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    rx_state_t          rx_state_q, rx_state_d;
    tx_state_t          tx_state_q, tx_state_d;
    logic [15:0]        asm_q, asm_d;
    logic [C_CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [23:0]        cmd_q, cmd_d;
    logic               cmd_rdy_q, cmd_rdy_d;
    logic               frame_err_q, frame_err_d;
    logic               trmt_q, trmt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               resp_sent_q, resp_sent_d;

    // While a command is held, the next byte stays pending in the transceiver.
    assign clr_rx_rdy = rx_rdy && (rx_state_q != CMD_VALID);

    always_comb begin
        rx_state_d  = rx_state_q;
        asm_d       = asm_q;
        to_cnt_d    = '0;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q;
        frame_err_d = 1'b0;
        unique case (rx_state_q)
            WAIT_B0: begin
                if (rx_rdy) begin
                    asm_d[15:8] = rx_data;
                    rx_state_d  = WAIT_B1;
                end
            end
            WAIT_B1, WAIT_B2: begin
                if (rx_rdy) begin
                    if (rx_state_q == WAIT_B1) begin
                        asm_d[7:0] = rx_data;
                        rx_state_d = WAIT_B2;
                    end else begin
                        cmd_d      = {asm_q, rx_data};
                        cmd_rdy_d  = 1'b1;
                        rx_state_d = CMD_VALID;
                    end
                end else if (to_cnt_q == C_TO_LAST) begin
                    // Gap too long: drop the partial frame and resync on the next byte.
                    asm_d       = '0;
                    frame_err_d = 1'b1;
                    rx_state_d  = WAIT_B0;
                end else begin
                    to_cnt_d = to_cnt_q + C_CNT_W'(1);
                end
            end
            CMD_VALID: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d  = 1'b0;
                    rx_state_d = WAIT_B0;
                end
            end
            default: rx_state_d = WAIT_B0;
        endcase
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_d  = resp;
                    trmt_d     = 1'b1;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q  <= WAIT_B0;
            tx_state_q  <= TX_IDLE;
            asm_q       <= '0;
            to_cnt_q    <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            trmt_q      <= 1'b0;
            tx_data_q   <= '0;
            resp_sent_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            asm_q       <= asm_d;
            to_cnt_q    <= to_cnt_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            frame_err_q <= frame_err_d;
            trmt_q      <= trmt_d;
            tx_data_q   <= tx_data_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frame_err = frame_err_q;
    assign trmt      = trmt_q;
    assign tx_data   = tx_data_q;
    assign resp_sent = resp_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_slave.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_slave : two instances (default and short timeout) checked every
//                     cycle against a frame-level model. Revision 1.0
// ============================================================================
module tb_uart_cmd_slave;

    localparam int TO_A = 1000000;
    localparam int TO_B = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      rx_rdy;
    logic [1:0][7:0] rx_data;
    logic            clr_cmd_rdy, send_resp, tx_done;
    logic [7:0]      resp;

    logic [1:0]       clr_rx_rdy, cmd_rdy, trmt, resp_sent, frame_err;
    logic [1:0][23:0] cmd;
    logic [1:0][7:0]  tx_data;

    always #5 clk = ~clk;

    uart_cmd_slave #(.TO_CYCLES(TO_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy[0]), .rx_data(rx_data[0]),
        .clr_rx_rdy(clr_rx_rdy[0]), .cmd(cmd[0]), .cmd_rdy(cmd_rdy[0]),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .trmt(trmt[0]), .tx_data(tx_data[0]), .tx_done(tx_done),
        .resp_sent(resp_sent[0]), .frame_err(frame_err[0])
    );

    uart_cmd_slave #(.TO_CYCLES(TO_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy[1]), .rx_data(rx_data[1]),
        .clr_rx_rdy(clr_rx_rdy[1]), .cmd(cmd[1]), .cmd_rdy(cmd_rdy[1]),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .trmt(trmt[1]), .tx_data(tx_data[1]), .tx_done(tx_done),
        .resp_sent(resp_sent[1]), .frame_err(frame_err[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d): got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Frame-level model: bytes collected so far, idle cycles since the last byte.
    int         m_n[2], m_idle[2];
    logic [7:0] m_b[2][2];
    logic [23:0] m_cmd[2];
    logic [7:0] m_tx[2];
    bit         m_cmd_rdy[2], m_ferr[2], m_busy[2], m_trmt[2], m_rsent[2];
    int         cnt_clr[2], cnt_ferr[2], cnt_trmt[2], cnt_rsent[2];

    function automatic int to_of(input int k);
        return (k == 0) ? TO_A : TO_B;
    endfunction

    task automatic model_reset(input int k);
        m_n[k] = 0; m_idle[k] = 0; m_cmd[k] = '0; m_tx[k] = '0;
        m_cmd_rdy[k] = 0; m_ferr[k] = 0; m_busy[k] = 0; m_trmt[k] = 0; m_rsent[k] = 0;
    endtask

    task automatic model_step(input int k);
        m_ferr[k] = 0; m_trmt[k] = 0; m_rsent[k] = 0;
        if (m_cmd_rdy[k]) begin
            if (clr_cmd_rdy) m_cmd_rdy[k] = 0;
        end else if (rx_rdy[k]) begin
            m_idle[k] = 0;
            if (m_n[k] == 2) begin
                m_cmd[k] = {m_b[k][0], m_b[k][1], rx_data[k]};
                m_cmd_rdy[k] = 1;
                m_n[k] = 0;
            end else begin
                m_b[k][m_n[k]] = rx_data[k];
                m_n[k]++;
            end
        end else if (m_n[k] > 0) begin
            m_idle[k]++;
            if (m_idle[k] == to_of(k)) begin
                m_n[k] = 0; m_idle[k] = 0; m_ferr[k] = 1;
            end
        end
        if (m_busy[k]) begin
            if (tx_done) begin m_rsent[k] = 1; m_busy[k] = 0; end
        end else if (send_resp) begin
            m_tx[k] = resp; m_trmt[k] = 1; m_busy[k] = 1;
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) model_reset(k);
            chk("clr_rx_rdy", k, 32'(clr_rx_rdy[k]), 32'(rx_rdy[k] && !m_cmd_rdy[k]));
            chk("cmd",        k, 32'(cmd[k]),        32'(m_cmd[k]));
            chk("cmd_rdy",    k, 32'(cmd_rdy[k]),    32'(m_cmd_rdy[k]));
            chk("frame_err",  k, 32'(frame_err[k]),  32'(m_ferr[k]));
            chk("trmt",       k, 32'(trmt[k]),       32'(m_trmt[k]));
            chk("tx_data",    k, 32'(tx_data[k]),    32'(m_tx[k]));
            chk("resp_sent",  k, 32'(resp_sent[k]),  32'(m_rsent[k]));
            if (clr_rx_rdy[k]) cnt_clr[k]++;
            if (frame_err[k])  cnt_ferr[k]++;
            if (trmt[k])       cnt_trmt[k]++;
            if (resp_sent[k])  cnt_rsent[k]++;
            if (rst_n) model_step(k);
        end
    end

    // Transceiver stand-in: holds each queued byte pending until it is consumed.
    logic [7:0] qa[$], qb[$];

    initial begin : xcvr
        bit [1:0] seen;
        rx_rdy  = '0;
        rx_data = '0;
        forever begin
            @(negedge clk);
            seen = clr_rx_rdy;
            @(posedge clk);
            #2;
            if (!rst_n) begin
                rx_rdy = '0;
                qa.delete();
                qb.delete();
            end else begin
                if (seen[0]) rx_rdy[0] = 1'b0;
                if (seen[1]) rx_rdy[1] = 1'b0;
                if (!rx_rdy[0] && qa.size() > 0) begin rx_data[0] = qa.pop_front(); rx_rdy[0] = 1'b1; end
                if (!rx_rdy[1] && qb.size() > 0) begin rx_data[1] = qb.pop_front(); rx_rdy[1] = 1'b1; end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit [1:0] mask, input logic [7:0] b);
        if (mask[0]) qa.push_back(b);
        if (mask[1]) qb.push_back(b);
    endtask

    task automatic wait_idle(input int k);
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #3;
            done = (k == 0) ? (!rx_rdy[0] && qa.size() == 0) : (!rx_rdy[1] && qb.size() == 0);
        end
        chk("byte_consumed", k, 32'(done), 32'd1);
    endtask

    task automatic pulse_clr_cmd();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stim
        int c, f, r, s;
        rst_n = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; tx_done = 1'b0; resp = '0;
        repeat (3) tick();
        chk("reset_cmd",     0, 32'(cmd[0]),     32'h0);
        chk("reset_cmd_rdy", 0, 32'(cmd_rdy[0]), 32'h0);
        chk("reset_tx_data", 0, 32'(tx_data[0]), 32'h0);
        rst_n = 1'b1;
        tick();

        // Three bytes 50 cycles apart
        c = cnt_clr[0];
        push(2'b11, 8'hA5); wait_idle(0); repeat (50) tick();
        push(2'b11, 8'h3C); wait_idle(0); repeat (50) tick();
        push(2'b11, 8'h0F); wait_idle(0);
        chk("frame1_cmd",     0, 32'(cmd[0]),         32'hA53C0F);
        chk("frame1_cmd_rdy", 0, 32'(cmd_rdy[0]),     32'h1);
        chk("frame1_clr_cnt", 0, 32'(cnt_clr[0] - c), 32'd3);
        repeat (100) tick();
        chk("cmd_rdy_held",   0, 32'(cmd_rdy[0]),     32'h1);

        // Byte arriving while a command is held
        c = cnt_clr[0];
        push(2'b01, 8'h11); repeat (5) tick();
        chk("hold_no_clr",    0, 32'(cnt_clr[0] - c), 32'd0);
        chk("hold_pending",   0, 32'(rx_rdy[0]),      32'h1);
        chk("hold_cmd",       0, 32'(cmd[0]),         32'hA53C0F);
        pulse_clr_cmd();
        chk("cleared_rdy",    0, 32'(cmd_rdy[0]),     32'h0);
        chk("cleared_cmd",    0, 32'(cmd[0]),         32'hA53C0F);
        chk("same_edge_skip", 0, 32'(cnt_clr[0] - c), 32'd0);
        tick();
        chk("next_cycle_take",0, 32'(cnt_clr[0] - c), 32'd1);
        push(2'b01, 8'h22); wait_idle(0);
        push(2'b01, 8'h33); wait_idle(0);
        chk("frame2_cmd",     0, 32'(cmd[0]),         32'h112233);
        pulse_clr_cmd();

        // Inter-byte timeout on the short-timeout instance
        do_reset();
        f = cnt_ferr[1];
        push(2'b10, 8'hDE); wait_idle(1);
        push(2'b10, 8'hAD); wait_idle(1);
        repeat (14) tick();
        chk("no_err_early",   1, 32'(cnt_ferr[1] - f), 32'd0);
        repeat (6) tick();
        chk("one_frame_err",  1, 32'(cnt_ferr[1] - f), 32'd1);
        chk("err_cmd_rdy",    1, 32'(cmd_rdy[1]),      32'h0);
        push(2'b10, 8'h01); wait_idle(1);
        push(2'b10, 8'h02); wait_idle(1);
        push(2'b10, 8'h03); wait_idle(1);
        chk("resync_cmd",     1, 32'(cmd[1]),          32'h010203);
        pulse_clr_cmd();

        // Second byte lands in the expiry cycle
        f = cnt_ferr[1];
        push(2'b10, 8'h77); wait_idle(1);
        repeat (15) @(posedge clk);
        #1;
        push(2'b10, 8'h88); wait_idle(1);
        push(2'b10, 8'h99); wait_idle(1);
        chk("expiry_no_err",  1, 32'(cnt_ferr[1] - f), 32'd0);
        chk("expiry_cmd",     1, 32'(cmd[1]),          32'h778899);
        pulse_clr_cmd();

        // Response transmit path
        r = cnt_trmt[0]; s = cnt_rsent[0];
        resp = 8'hA5; send_resp = 1'b1; tick(); send_resp = 1'b0;
        chk("trmt_pulse",     0, 32'(trmt[0]),    32'h1);
        chk("tx_data_a5",     0, 32'(tx_data[0]), 32'hA5);
        tick();
        chk("trmt_one_cycle", 0, 32'(trmt[0]),    32'h0);
        resp = 8'h5A; send_resp = 1'b1; tick(); send_resp = 1'b0; tick();
        chk("busy_no_trmt",   0, 32'(cnt_trmt[0] - r), 32'd1);
        chk("busy_tx_data",   0, 32'(tx_data[0]),      32'hA5);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        chk("resp_sent",      0, 32'(resp_sent[0]),    32'h1);
        tick();
        chk("resp_sent_once", 0, 32'(cnt_rsent[0] - s), 32'd1);
        resp = 8'hC3; send_resp = 1'b1; tick(); send_resp = 1'b0;
        repeat (3) tick();
        resp = 8'h3C; send_resp = 1'b1; tx_done = 1'b1; tick();
        send_resp = 1'b0; tx_done = 1'b0;
        tick();
        chk("done_edge_send", 0, 32'(cnt_trmt[0] - r), 32'd2);
        chk("done_edge_data", 0, 32'(tx_data[0]),      32'hC3);

        // Reset mid-frame and mid-transmit
        push(2'b11, 8'hAB); push(2'b11, 8'hCD); push(2'b11, 8'hEF); wait_idle(0);
        chk("pre_reset_cmd",  0, 32'(cmd[0]),     32'hABCDEF);
        pulse_clr_cmd();
        push(2'b11, 8'h12); wait_idle(0);
        resp = 8'h66; send_resp = 1'b1; tick(); send_resp = 1'b0; tick();
        rst_n = 1'b0;
        #1;
        chk("rst_cmd",        0, 32'(cmd[0]),       32'h0);
        chk("rst_cmd_rdy",    0, 32'(cmd_rdy[0]),   32'h0);
        chk("rst_trmt",       0, 32'(trmt[0]),      32'h0);
        chk("rst_tx_data",    0, 32'(tx_data[0]),   32'h0);
        chk("rst_resp_sent",  0, 32'(resp_sent[0]), 32'h0);
        chk("rst_frame_err",  0, 32'(frame_err[0]), 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        push(2'b11, 8'h12); push(2'b11, 8'h34); push(2'b11, 8'h56); wait_idle(0);
        chk("post_rst_cmd",   0, 32'(cmd[0]),       32'h123456);
        resp = 8'h3C; send_resp = 1'b1; tick(); send_resp = 1'b0;
        chk("post_rst_trmt",  0, 32'(trmt[0]),      32'h1);
        chk("post_rst_data",  0, 32'(tx_data[0]),   32'h3C);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        chk("post_rst_sent",  0, 32'(resp_sent[0]), 32'h1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
